irq_sequencer: RTL and testbench
================================

# irq_sequencer

Clocked interrupt sequencer for the programmable interrupt controller. It latches the eight IR lines into the request register (IRR) and masks them with the interrupt mask register (IMR). It resolves priority against the in-service register (ISR) in fully nested mode, raises INT, and runs the two-pulse INTA handshake that drives the vector byte onto the data path. It also retires in-service levels on EOI or AEOI, and sits between the IR pins and the command/data-bus buffer.

## Interface
- NUM_IR, 8, number of interrupt request lines; fixed at 8 for vector format
- clk  in  1  system clock; all state changes on rising edge
- rst_n  in  1  asynchronous active-low reset
- ir  in  8  raw interrupt requests, synchronous to clk
- imr  in  8  mask (1 = masked), from OCW1 register
- vec_base  in  5  T7..T3 from ICW2
- ltim  in  1  1 = level-triggered, 0 = edge-triggered (ICW1 bit 3)
- aeoi  in  1  automatic EOI enable (ICW4 bit 1)
- eoi  in  1  one-cycle pulse: non-specific EOI command (OCW2)
- inta_n  in  1  interrupt acknowledge, active low, synchronous to clk
- int_out  out  1  interrupt request to CPU
- vector  out  8  {vec_base, level}; valid when vector_valid
- vector_valid  out  1  drive data bus with vector
- irr  out  8  request register
- isr  out  8  in-service register

## Operation
- Reset values: irr=0, isr=0, int_out=0, vector=0, vector_valid=0, state IDLE, rotation pointer=7 (IR0 highest).
- IRR, edge mode: bit n sets on a 0->1 of ir[n] between consecutive clk samples. Bit n clears when ISR bit n is set, or when ir[n] is low at first INTA.
- IRR, level mode: bit n equals the registered ir[n]; no latching.
- Candidate: the highest-priority bit of irr & ~imr, provided it beats the highest-priority isr bit. Equal or lower priority is blocked.
- FSM:
  - IDLE -> REQ when a candidate exists; int_out=1.
  - REQ -> IDLE if the candidate vanishes before INTA; int_out=0.
  - REQ -> ACK1 on the first inta_n falling edge. The current candidate is frozen as the level. isr[level] is set, irr[level] is cleared in edge mode, and int_out=0.
  - No candidate at the first INTA: spurious. Level=7, ISR is not set.
  - ACK1 -> ACK2 on the second falling edge. vector={vec_base, level} and vector_valid=1.
  - ACK2 -> IDLE on the inta_n rising edge. vector_valid=0. If aeoi=1 and the cycle is not spurious, isr[level] is cleared.
- eoi: clears the highest-priority set ISR bit. With no ISR bit set, eoi has no effect.
- Simultaneous eoi and first INTA: the EOI clears from the ISR value before the new bit is set.
- A new candidate during ACK1/ACK2 is held. int_out re-asserts in IDLE on the next evaluation.
- imr changes take effect the next cycle. Masking a level in REQ returns the FSM to IDLE if no other candidate exists.

## Timing
- ir -> irr: 1 cycle (registered sample, plus edge compare).
- irr -> int_out: 1 cycle (registered priority result). ir rising to int_out high takes 2 cycles.
- inta_n is registered once. A falling edge is detected as prev=1, cur=0. The action lands on the following clock edge.
- vector_valid rises 1 cycle after the second falling edge is detected. It falls 1 cycle after the rising edge is detected.
- eoi: isr updates on the same rising edge that samples eoi=1.
- rst_n assertion mid-handshake clears everything immediately. INTA pulses after reset are ignored until a fresh REQ.

## Configuration
- ROTATE_PRIORITY_EN defined: automatic rotation. When an ISR bit n is cleared by eoi or AEOI, IR n becomes lowest priority and IR(n+1 mod 8) becomes highest. Priority compares use the pointer.
- ROTATE_PRIORITY_EN undefined: fixed priority, IR0 highest and IR7 lowest. No pointer register exists.

## Test plan
- Reset then ir=8'h04, imr=0, vec_base=5'h10: int_out high 2 cycles later; two INTA pulses -> vector=8'h82, isr=8'h04, irr=0.
- isr=8'h04 in service, ir[5] rises: int_out stays 0. ir[1] rises: int_out=1, second INTA gives vector 8'h81 and isr=8'h06. eoi -> isr=8'h04.
- Edge mode: ir[3] pulses high, then drops before the first INTA after int_out -> spurious. vector={vec_base,3'd7}, isr unchanged.
- aeoi=1, IR6 request: after the INTA rising edge, isr=0. A held-high level-mode ir[6] re-raises int_out.
- ROTATE_PRIORITY_EN: service and eoi IR2, then ir=8'h12 simultaneously -> IR4 wins (vector low bits 3'd4) before IR1.
- rst_n pulse low in ACK1: isr=irr=0, int_out=0, vector_valid=0. A subsequent INTA produces no vector.

Source files
------------

// File: rtl/irq_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : irq_sequencer_if
//  Description : CPU-facing interrupt acknowledge bus for the interrupt
//                sequencer: INT request, active-low INTA strobe and the
//                vector byte driven during the second acknowledge pulse.
//  Signals     : inta_n       - interrupt acknowledge from CPU (active low)
//                int_out      - interrupt request to CPU
//                vector       - {vec_base, level}, valid with vector_valid
//                vector_valid - sequencer is driving the vector byte
//  Revision    : 1.0 - initial release
// ============================================================================
interface irq_sequencer_if;
  logic       inta_n;
  logic       int_out;
  logic [7:0] vector;
  logic       vector_valid;

  // CPU side
  modport master (
    output inta_n,
    input  int_out,
    input  vector,
    input  vector_valid
  );

  // Sequencer side
  modport slave (
    input  inta_n,
    output int_out,
    output vector,
    output vector_valid
  );
endinterface
`default_nettype wire

// File: rtl/irq_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : irq_sequencer
//  Description : Interrupt sequencer of the programmable interrupt controller.
//                Latches IR lines into IRR, masks with IMR, resolves fully
//                nested priority against ISR, raises INT and runs the
//                two-pulse INTA handshake delivering the vector byte. Retires
//                in-service levels on non-specific EOI or AEOI.
//  Ports       : clk, rst_n    - clock, asynchronous active-low reset
//                ir            - raw interrupt requests
//                imr           - mask (1 = masked)
//                vec_base      - vector bits T7..T3
//                ltim          - 1 = level triggered, 0 = edge triggered
//                aeoi          - automatic EOI enable
//                eoi           - one-cycle non-specific EOI pulse
//                bus (slave)   - inta_n / int_out / vector / vector_valid
//                irr, isr      - request and in-service registers
//  Options     : ROTATE_PRIORITY_EN - automatic priority rotation on EOI/AEOI
//  Revision    : 1.0 - initial release
// ============================================================================
module irq_sequencer #(
  parameter int NUM_IR = 8
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic [NUM_IR-1:0] ir,
  input  wire logic [NUM_IR-1:0] imr,
  input  wire logic [4:0]        vec_base,
  input  wire logic              ltim,
  input  wire logic              aeoi,
  input  wire logic              eoi,
  irq_sequencer_if.slave         bus,
  output logic      [NUM_IR-1:0] irr,
  output logic      [NUM_IR-1:0] isr
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_ACK1 = 2'd2,
    S_ACK2 = 2'd3
  } state_t;

  // Pointer names the lowest-priority level; 7 gives IR0 highest.
  localparam logic [2:0] c_PTR_RESET = 3'd7;

  // Rank 0 is the highest priority for the given pointer.
  function automatic logic [2:0] f_rank(input logic [2:0] idx, input logic [2:0] ptr);
    return idx - ptr - 3'd1;
  endfunction

  // Returns {found, index} of the highest-priority set bit.
  function automatic logic [3:0] f_pick(input logic [NUM_IR-1:0] req, input logic [2:0] ptr);
    logic [3:0] res;
    logic [2:0] idx;
    res = 4'd0;
    for (int i = NUM_IR - 1; i >= 0; i--) begin
      idx = ptr + 3'd1 + 3'(i);
      if (req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  // Highest request that strictly beats the highest in-service level.
  function automatic logic [3:0] f_cand(input logic [NUM_IR-1:0] req,
                                        input logic [NUM_IR-1:0] srv,
                                        input logic [2:0]        ptr);
    logic [3:0] p;
    logic [3:0] s;
    p = f_pick(req, ptr);
    s = f_pick(srv, ptr);
    if (p[3] && (!s[3] || (f_rank(p[2:0], ptr) < f_rank(s[2:0], ptr))))
      return p;
    return 4'd0;
  endfunction

  state_t            r_state;
  state_t            w_state_nxt;
  logic [NUM_IR-1:0] r_ir_q;
  logic              r_inta_q;
  logic              r_inta_qq;
  logic [NUM_IR-1:0] r_irr;
  logic [NUM_IR-1:0] r_isr;
  logic [2:0]        r_level;
  logic              r_spurious;
  logic [7:0]        r_vector;
  logic              r_vector_valid;
  logic [2:0]        w_ptr;

  logic              w_inta_fall;
  logic              w_inta_rise;
  logic [3:0]        w_cand;
  logic [3:0]        w_ack_cand;
  logic [3:0]        w_isr_top;
  logic              w_ack;
  logic              w_vec_load;
  logic              w_done;
  logic [NUM_IR-1:0] w_ack_set;
  logic [NUM_IR-1:0] w_eoi_clr;
  logic [NUM_IR-1:0] w_aeoi_clr;
  logic [NUM_IR-1:0] w_irr_nxt;
  logic [NUM_IR-1:0] w_isr_nxt;

`ifdef ROTATE_PRIORITY_EN
  logic [2:0] r_ptr;
  assign w_ptr = r_ptr;

  // Retired level becomes the lowest priority; AEOI and EOI are exclusive in
  // practice, AEOI takes precedence if both land together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                r_ptr <= c_PTR_RESET;
    else if (|w_aeoi_clr)      r_ptr <= r_level;
    else if (|w_eoi_clr)       r_ptr <= w_isr_top[2:0];
  end
`else
  assign w_ptr = c_PTR_RESET;
`endif

  assign w_inta_fall = r_inta_qq & ~r_inta_q;
  assign w_inta_rise = ~r_inta_qq & r_inta_q;

  assign w_cand    = f_cand(r_irr & ~imr, r_isr, w_ptr);
  // At the first INTA a request only counts if its line is still high;
  // a pulse that already dropped makes the cycle spurious.
  assign w_ack_cand = f_cand(r_irr & r_ir_q & ~imr, r_isr, w_ptr);
  assign w_isr_top  = f_pick(r_isr, w_ptr);

  always_comb begin
    w_state_nxt = r_state;
    w_ack       = 1'b0;
    w_vec_load  = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: if (w_cand[3]) w_state_nxt = S_REQ;
      S_REQ: begin
        if (w_inta_fall) begin
          w_state_nxt = S_ACK1;
          w_ack       = 1'b1;
        end else if (!w_cand[3]) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ACK1: begin
        if (w_inta_fall) begin
          w_state_nxt = S_ACK2;
          w_vec_load  = 1'b1;
        end
      end
      S_ACK2: begin
        if (w_inta_rise) begin
          w_state_nxt = S_IDLE;
          w_done      = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_ack_set  = (w_ack && w_ack_cand[3]) ? (NUM_IR'(1) << w_ack_cand[2:0]) : '0;
  assign w_eoi_clr  = (eoi && w_isr_top[3]) ? (NUM_IR'(1) << w_isr_top[2:0]) : '0;
  assign w_aeoi_clr = (w_done && aeoi && !r_spurious) ? (NUM_IR'(1) << r_level) : '0;

  // EOI/AEOI clear first, then the newly acknowledged level is set.
  assign w_isr_nxt = (r_isr & ~w_eoi_clr & ~w_aeoi_clr) | w_ack_set;

  always_comb begin
    w_irr_nxt = (r_irr & ~(w_ack ? (~r_ir_q | w_ack_set) : '0)) | (ir & ~r_ir_q);
    if (ltim) w_irr_nxt = ir;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_ir_q         <= '0;
      r_inta_q       <= 1'b1;
      r_inta_qq      <= 1'b1;
      r_irr          <= '0;
      r_isr          <= '0;
      r_level        <= 3'd7;
      r_spurious     <= 1'b0;
      r_vector       <= 8'd0;
      r_vector_valid <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ir_q    <= ir;
      r_inta_q  <= bus.inta_n;
      r_inta_qq <= r_inta_q;
      r_irr     <= w_irr_nxt;
      r_isr     <= w_isr_nxt;
      if (w_ack) begin
        r_level    <= w_ack_cand[3] ? w_ack_cand[2:0] : 3'd7;
        r_spurious <= ~w_ack_cand[3];
      end
      if (w_vec_load) begin
        r_vector       <= {vec_base, r_level};
        r_vector_valid <= 1'b1;
      end else if (w_done) begin
        r_vector_valid <= 1'b0;
      end
    end
  end

  assign bus.int_out      = (r_state == S_REQ);
  assign bus.vector       = r_vector;
  assign bus.vector_valid = r_vector_valid;
  assign irr              = r_irr;
  assign isr              = r_isr;

endmodule
`default_nettype wire

// File: tb/tb_irq_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_irq_sequencer
//  Description : Directed self-checking bench for irq_sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_irq_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] ir;
  logic [7:0] imr;
  logic [4:0] vec_base;
  logic       ltim;
  logic       aeoi;
  logic       eoi;
  logic [7:0] irr;
  logic [7:0] isr;

  int n_checks = 0;
  int n_pass   = 0;

  irq_sequencer_if bus ();

  irq_sequencer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ir       (ir),
    .imr      (imr),
    .vec_base (vec_base),
    .ltim     (ltim),
    .aeoi     (aeoi),
    .eoi      (eoi),
    .bus      (bus),
    .irr      (irr),
    .isr      (isr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    ir         = 8'h00;
    eoi        = 1'b0;
    bus.inta_n = 1'b1;
    tick(1);
    rst_n = 1'b1;
    tick(1);
  endtask

  // One INTA low/high pulse; captures the vector while inta_n is still low.
  task automatic inta_pulse(output logic vv, output logic [7:0] vec);
    bus.inta_n = 1'b0;
    tick(2);
    vv  = bus.vector_valid;
    vec = bus.vector;
    bus.inta_n = 1'b1;
    tick(2);
  endtask

  task automatic eoi_pulse();
    eoi = 1'b1;
    tick(1);
    eoi = 1'b0;
  endtask

  logic       vv;
  logic [7:0] vec;

  initial begin
    imr = 8'h00; vec_base = 5'h10; ltim = 1'b0; aeoi = 1'b0;
    do_reset();

    // Reset state
    check("rst_irr", irr, 8'h00);
    check("rst_isr", isr, 8'h00);
    check("rst_int", {7'd0, bus.int_out}, 8'h00);
    check("rst_vec", bus.vector, 8'h00);
    check("rst_vv",  {7'd0, bus.vector_valid}, 8'h00);

    // Basic IR2 service
    ir = 8'h04;
    tick(1);
    check("t1_irr", irr, 8'h04);
    check("t1_int_early", {7'd0, bus.int_out}, 8'h00);
    tick(1);
    check("t1_int", {7'd0, bus.int_out}, 8'h01);
    inta_pulse(vv, vec);
    check("t1_vv1", {7'd0, vv}, 8'h00);
    check("t1_isr_ack1", isr, 8'h04);
    check("t1_int_ack1", {7'd0, bus.int_out}, 8'h00);
    inta_pulse(vv, vec);
    check("t1_vv2", {7'd0, vv}, 8'h01);
    check("t1_vec", vec, 8'h82);
    check("t1_vv_end", {7'd0, bus.vector_valid}, 8'h00);
    check("t1_isr", isr, 8'h04);
    check("t1_irr_end", irr, 8'h00);

    // Nesting: lower priority blocked, higher priority served, then EOI
    ir = 8'h24;
    tick(3);
    check("t2_blocked", {7'd0, bus.int_out}, 8'h00);
    check("t2_irr5", irr, 8'h20);
    ir = 8'h26;
    tick(2);
    check("t2_int", {7'd0, bus.int_out}, 8'h01);
    inta_pulse(vv, vec);
    inta_pulse(vv, vec);
    check("t2_vec", vec, 8'h81);
    check("t2_isr", isr, 8'h06);
    eoi_pulse();
    check("t2_eoi", isr, 8'h04);

    // Spurious: edge request drops before first INTA
    do_reset();
    ir = 8'h08;
    tick(1);
    ir = 8'h00;
    tick(1);
    check("t3_int", {7'd0, bus.int_out}, 8'h01);
    inta_pulse(vv, vec);
    inta_pulse(vv, vec);
    check("t3_vec", vec, 8'h87);
    check("t3_isr", isr, 8'h00);
    check("t3_irr", irr, 8'h00);
    eoi_pulse();
    check("t3_eoi_empty", isr, 8'h00);

    // AEOI with level-triggered IR6
    ltim = 1'b1; aeoi = 1'b1;
    do_reset();
    ir = 8'h40;
    tick(2);
    check("t4_int", {7'd0, bus.int_out}, 8'h01);
    inta_pulse(vv, vec);
    check("t4_isr_ack1", isr, 8'h40);
    check("t4_irr_level", irr, 8'h40);
    inta_pulse(vv, vec);
    check("t4_vec", vec, 8'h86);
    check("t4_isr_aeoi", isr, 8'h00);
    tick(1);
    check("t4_reraise", {7'd0, bus.int_out}, 8'h01);
    ltim = 1'b0; aeoi = 1'b0;

    // Priority after servicing IR2
    do_reset();
    ir = 8'h04;
    tick(2);
    inta_pulse(vv, vec);
    inta_pulse(vv, vec);
    eoi_pulse();
    check("t5_isr_clr", isr, 8'h00);
    ir = 8'h12;
    tick(2);
    check("t5_int", {7'd0, bus.int_out}, 8'h01);
    inta_pulse(vv, vec);
    inta_pulse(vv, vec);
`ifdef ROTATE_PRIORITY_EN
    check("t5_vec_rot", vec, 8'h84);
`else
    check("t5_vec_fixed", vec, 8'h81);
`endif

    // Masking a pending level in REQ
    do_reset();
    ir = 8'h01;
    tick(2);
    check("t7_int", {7'd0, bus.int_out}, 8'h01);
    imr = 8'h01;
    tick(1);
    check("t7_masked", {7'd0, bus.int_out}, 8'h00);
    imr = 8'h00;
    tick(1);
    check("t7_unmasked", {7'd0, bus.int_out}, 8'h01);

    // Reset in the middle of the handshake
    do_reset();
    ir = 8'h04;
    tick(2);
    bus.inta_n = 1'b0;
    tick(2);
    check("t6_isr_ack1", isr, 8'h04);
    rst_n = 1'b0;
    ir = 8'h00;
    bus.inta_n = 1'b1;
    #1;
    check("t6_isr", isr, 8'h00);
    check("t6_irr", irr, 8'h00);
    check("t6_int", {7'd0, bus.int_out}, 8'h00);
    check("t6_vv", {7'd0, bus.vector_valid}, 8'h00);
    tick(1);
    rst_n = 1'b1;
    tick(1);
    inta_pulse(vv, vec);
    check("t6_vv_p1", {7'd0, vv}, 8'h00);
    inta_pulse(vv, vec);
    check("t6_vv_p2", {7'd0, vv}, 8'h00);
    check("t6_isr_end", isr, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
